rtc_bus_scheduler: RTL and testbench

Sequencer and arbiter in front of the RTC register controller. It periodically sweeps the six RTC time/date registers (33–38) and shares the controller with one user write requester, e.g. keyboard or configuration logic. It drives the controller's cs/strobe/address/data bus and collects read results into staging registers. The result is published as one consistent time/date snapshot.

---
 rtl/rtc_sched_pkg.sv | 28 ++
 rtl/rtc_refresh_timer.sv | 22 ++
 rtl/rtc_bus_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_rtc_bus_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_sched_pkg.sv
// Shared state encoding, poll addresses and sweep sizing for the RTC bus scheduler.
package rtc_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  localparam int N_POLL = 6;
  localparam int IDX_W  = 3;

  localparam logic [7:0] ADDR_SEG  = 8'd33;
  localparam logic [7:0] ADDR_MIN  = 8'd34;
  localparam logic [7:0] ADDR_HORA = 8'd35;
  localparam logic [7:0] ADDR_DIA  = 8'd36;
  localparam logic [7:0] ADDR_MES  = 8'd37;
  localparam logic [7:0] ADDR_ANIO = 8'd38;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_POLL - 1);

  function automatic logic [7:0] poll_addr(input logic [IDX_W-1:0] idx);
    return ADDR_SEG + 8'(idx);
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Free-running 0..REFRESH_CYCLES-1 counter; tick is high for the one cycle before each wrap.
module rtc_refresh_timer #(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset)    count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 1'b1;
  end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Shares the RTC register controller between periodic time/date sweeps and one user
// write requester, publishing registers 33..38 as one consistent snapshot.
//
// state  | meaning
// IDLE   | pick next transaction: pending write first, then sweep read
// ISSUE  | cs and the matching strobe held for CS_HOLD cycles
// WAIT   | bus released, waiting for txn_done or TIMEOUT
// COMMIT | write ack, or advance / publish the sweep
// GAP    | one idle bus cycle, then IDLE
module rtc_bus_scheduler
  import rtc_sched_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000,
  parameter int CS_HOLD        = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_en,
  input  logic       wr_req,
  input  logic [7:0] wr_dir,
  input  logic [7:0] wr_dato,
  output logic       wr_ack,
  output logic       cs,
  output logic       writestrobe,
  output logic       readstrobe,
  output logic [7:0] dir,
  output logic [7:0] dato,
  input  logic       txn_done,
  input  logic [7:0] rd_data,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       upd,
  output logic       busy,
  output logic       timeout_err
);

  localparam int CNT_MAX = (CS_HOLD > TIMEOUT) ? CS_HOLD : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             is_write;
  logic             poll_pending;
  logic             tick;
  logic             start_write, start_read, txn_ok, txn_abort;
  logic [7:0]       stage [N_POLL];

  rtc_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_write = 1'b0;
    start_read  = 1'b0;
    txn_ok      = 1'b0;
    txn_abort   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_req) begin
          start_write = 1'b1;
          state_next  = ST_ISSUE;
        end else if (poll_pending && rd_en) begin
          start_read = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cnt == '0) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (txn_done) begin
          txn_ok     = 1'b1;
          state_next = ST_COMMIT;
        end else if (cnt == '0) begin
          txn_abort  = 1'b1;
          state_next = ST_GAP;
        end
      end
      ST_COMMIT: state_next = ST_GAP;
      ST_GAP:    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign cs          = (state == ST_ISSUE);
  assign writestrobe = cs & is_write;
  assign readstrobe  = cs & ~is_write;
  assign busy        = (state != ST_IDLE);

  // One counter serves both the ISSUE hold and the WAIT timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      is_write <= 1'b0;
      dir      <= '0;
      dato     <= '0;
      cnt      <= '0;
    end else if (start_write) begin
      is_write <= 1'b1;
      dir      <= wr_dir;
      dato     <= wr_dato;
      cnt      <= CNT_W'(CS_HOLD - 1);
    end else if (start_read) begin
      is_write <= 1'b0;
      dir      <= poll_addr(idx);
      cnt      <= CNT_W'(CS_HOLD - 1);
    end else if (state == ST_ISSUE) begin
      cnt <= (cnt == '0) ? CNT_W'(TIMEOUT - 1) : cnt - 1'b1;
    end else if (state == ST_WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_POLL; i++) stage[i] <= '0;
    end else if (txn_ok && !is_write) begin
      for (int i = 0; i < N_POLL; i++) begin
        if (idx == IDX_W'(i)) stage[i] <= rd_data;
      end
    end
  end

  // A tick on the same edge as a sweep clear wins, so that wrap is not lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx          <= '0;
      poll_pending <= 1'b1;
      wr_ack       <= 1'b0;
      upd          <= 1'b0;
      timeout_err  <= 1'b0;
      seg          <= '0;
      min          <= '0;
      hora         <= '0;
      dia          <= '0;
      mes          <= '0;
      anio         <= '0;
    end else begin
      wr_ack <= (txn_ok | txn_abort) & is_write;
      upd    <= 1'b0;
      if (txn_abort) begin
        timeout_err <= 1'b1;
        if (!is_write) begin
          idx          <= '0;
          poll_pending <= 1'b0;
        end
      end
      if (state == ST_COMMIT && !is_write) begin
        if (idx == IDX_LAST) begin
          seg          <= stage[0];
          min          <= stage[1];
          hora         <= stage[2];
          dia          <= stage[3];
          mes          <= stage[4];
          anio         <= stage[5];
          upd          <= 1'b1;
          idx          <= '0;
          poll_pending <= 1'b0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (tick) poll_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Randomized bench: each transaction is predicted as a timeline (start, hold, response
// offset) from which every output of every cycle is derived and compared.
module tb_rtc_bus_scheduler;

  localparam int R      = 50;
  localparam int H      = 3;
  localparam int T      = 9;
  localparam int CYCLES = 8000;

  logic       clk = 1'b0;
  logic       reset, rd_en, wr_req, txn_done;
  logic [7:0] wr_dir, wr_dato, rd_data;
  logic       wr_ack, cs, writestrobe, readstrobe, upd, busy, timeout_err;
  logic [7:0] dir, dato, seg, min, hora, dia, mes, anio;

  always #5 clk = ~clk;

  rtc_bus_scheduler #(
    .REFRESH_CYCLES(R),
    .CS_HOLD       (H),
    .TIMEOUT       (T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .wr_req     (wr_req),
    .wr_dir     (wr_dir),
    .wr_dato    (wr_dato),
    .wr_ack     (wr_ack),
    .cs         (cs),
    .writestrobe(writestrobe),
    .readstrobe (readstrobe),
    .dir        (dir),
    .dato       (dato),
    .txn_done   (txn_done),
    .rd_data    (rd_data),
    .seg        (seg),
    .min        (min),
    .hora       (hora),
    .dia        (dia),
    .mes        (mes),
    .anio       (anio),
    .upd        (upd),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // Reference state: sweep position, pending flag, staged and published bytes.
  bit         m_pending, m_terr;
  int         m_idx, since_rst;
  logic [7:0] m_stage [6];
  logic [7:0] m_snap  [6];
  logic [7:0] m_dir, m_dato;
  logic [7:0] first_sweep [6];

  // Current transaction timeline: first cs cycle, kind, sweep slot, response offset (-1 = none).
  bit t_act, t_wr;
  int t_s, t_r, t_idx, t_n;

  int n_rd_starts, n_upd_exp, n_upd_seen, rst_hold;
  bit first_seen;

  task automatic model_reset();
    m_pending = 1'b1;
    m_terr    = 1'b0;
    m_idx     = 0;
    since_rst = 0;
    m_dir     = '0;
    m_dato    = '0;
    t_act     = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_stage[i] = '0;
      m_snap[i]  = '0;
    end
  endtask

  function automatic int wait_len();
    return (t_r >= 0) ? t_r + 1 : T;
  endfunction

  function automatic int ack_cyc();
    return (t_r >= 0) ? t_s + H + t_r + 1 : t_s + H + T;
  endfunction

  function automatic int end_cyc();
    return (t_r >= 0) ? t_s + H + t_r + 3 : t_s + H + T + 1;
  endfunction

  function automatic int pick_resp();
    int k;
    k = int'($urandom_range(0, 11));
    if (k == 0) return -1;
    if (k == 1) return T - 1;
    return k % 4;
  endfunction

  function automatic logic [47:0] snap_exp();
    return {m_snap[0], m_snap[1], m_snap[2], m_snap[3], m_snap[4], m_snap[5]};
  endfunction

  initial begin
    first_sweep[0] = 8'h15; first_sweep[1] = 8'h30; first_sweep[2] = 8'h12;
    first_sweep[3] = 8'h07; first_sweep[4] = 8'h10; first_sweep[5] = 8'h16;
    reset = 1'b0; rd_en = 1'b1; wr_req = 1'b0; wr_dir = '0; wr_dato = '0;
    txn_done = 1'b0; rd_data = '0;
    n_rd_starts = 0; n_upd_exp = 0; n_upd_seen = 0; rst_hold = 0; first_seen = 1'b0;
    t_wr = 1'b0; t_s = 0; t_r = 0; t_idx = 0; t_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;

    for (cyc = 0; cyc < CYCLES; cyc++) begin
      bit exp_cs, in_wait, exp_ack, exp_upd, resp, tk;
      int w;

      exp_cs  = t_act && (cyc < t_s + H);
      w       = cyc - (t_s + H);
      in_wait = t_act && (w >= 0) && (w < wait_len());
      exp_ack = t_act && t_wr && (cyc == ack_cyc());
      exp_upd = t_act && !t_wr && (t_idx == 5) && (t_r >= 0) && (cyc == t_s + H + t_r + 2);

      check_val("busy",        busy,        t_act);
      check_val("cs",          cs,          exp_cs);
      check_val("writestrobe", writestrobe, exp_cs && t_wr);
      check_val("readstrobe",  readstrobe,  exp_cs && !t_wr);
      check_val("wr_ack",      wr_ack,      exp_ack);
      check_val("upd",         upd,         exp_upd);
      check_val("timeout_err", timeout_err, m_terr);
      check_val("dir",         dir,         m_dir);
      check_val("dato",        dato,        m_dato);
      check_val("snapshot",    {seg, min, hora, dia, mes, anio}, snap_exp());
      if (upd === 1'b1) begin
        n_upd_seen++;
        if (!first_seen) begin
          first_seen = 1'b1;
          check_val("basic_sweep_snapshot", {seg, min, hora, dia, mes, anio},
                    {first_sweep[0], first_sweep[1], first_sweep[2],
                     first_sweep[3], first_sweep[4], first_sweep[5]});
        end
      end

      // Stimulus for this cycle, sampled at the next rising edge.
      if (rst_hold == 0 && cyc > 100 &&
          (($urandom_range(0, 999) == 0) || (in_wait && t_wr && $urandom_range(0, 39) == 0)))
        rst_hold = int'($urandom_range(1, 2));
      reset = (rst_hold == 0);
      if (rst_hold > 0) rst_hold--;

      if (!reset || exp_ack) begin
        wr_req = 1'b0;
      end else if (!wr_req && cyc > 80 && $urandom_range(0, 24) == 0) begin
        wr_req  = 1'b1;
        wr_dir  = 8'($urandom);
        wr_dato = 8'($urandom);
      end

      if (cyc > 80 && $urandom_range(0, 59) == 0) rd_en = !rd_en;

      resp     = in_wait && (t_r >= 0) && (w == t_r);
      txn_done = resp || (!in_wait && $urandom_range(0, 7) == 0);
      rd_data  = 8'($urandom);
      if (resp && !t_wr && t_n < 6) rd_data = first_sweep[t_n];

      // Reference update for the edge that ends this cycle.
      if (!reset) begin
        model_reset();
      end else begin
        tk = ((since_rst % R) == R - 1);
        since_rst++;
        if (t_act) begin
          if (resp && !t_wr) m_stage[t_idx] = rd_data;
          if (t_r >= 0 && !t_wr && cyc == t_s + H + t_r + 1) begin
            if (t_idx == 5) begin
              for (int i = 0; i < 6; i++) m_snap[i] = m_stage[i];
              m_idx     = 0;
              m_pending = 1'b0;
              n_upd_exp++;
            end else begin
              m_idx = m_idx + 1;
            end
          end
          if (t_r < 0 && w == T - 1) begin
            m_terr = 1'b1;
            if (!t_wr) begin
              m_idx     = 0;
              m_pending = 1'b0;
            end
          end
          if (cyc == end_cyc() - 1) t_act = 1'b0;
        end else if (wr_req) begin
          t_act  = 1'b1;
          t_wr   = 1'b1;
          t_s    = cyc + 1;
          t_r    = pick_resp();
          t_n    = 6;
          m_dir  = wr_dir;
          m_dato = wr_dato;
        end else if (m_pending && rd_en) begin
          t_act = 1'b1;
          t_wr  = 1'b0;
          t_s   = cyc + 1;
          t_idx = m_idx;
          t_n   = n_rd_starts;
          t_r   = (n_rd_starts < 6) ? 1 : pick_resp();
          n_rd_starts++;
          m_dir = 8'(33 + m_idx);
        end
        if (tk) m_pending = 1'b1;
      end

      @(posedge clk);
      #1;
    end

    check_val("upd_count", 64'(n_upd_seen), 64'(n_upd_exp));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
